fire_expand_ofm_writer: RTL and testbench
=========================================

FIRE_EXPAND_OFM_WRITER -- requirements
Module: fire_expand_ofm_writer

Interface
REQ-001 SHALL have parameter DSP_NO, default 64: number of parallel OFM channels delivered per sample.
REQ-002 SHALL have parameter WIDTH, default 16: bits per OFM word.
REQ-003 SHALL have parameter WOUT, default 64: output map side; a layer is WOUT**2 pixels.
REQ-004 SHALL have parameter LANES, default 4: OFM words written per RAM beat; DSP_NO SHALL be a multiple of LANES.
REQ-005 SHALL have port clk, input, 1: clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port start, input, 1: layer enable, held high for the whole layer.
REQ-008 SHALL have port sample, input, 1: one-cycle pulse, ofm valid in the same cycle.
REQ-009 SHALL have port ofm, input, DSP_NO x WIDTH unpacked array: channel results of one pixel.
REQ-010 SHALL have port ram_we, output, 1: RAM write strobe.
REQ-011 SHALL have port ram_addr, output, clog2(WOUT**2*DSP_NO/LANES): beat address.
REQ-012 SHALL have port ram_wdata, output, LANES*WIDTH: lane 0 in the LSBs.
REQ-013 SHALL have port ram_feedback, output, 1: high while the writer is busy writing.
REQ-014 SHALL have port done, output, 1: all WOUT**2 pixels written.
REQ-015 SHALL have port overrun, output, 1: sticky error flag, see Configuration.

Function
REQ-016 States SHALL be IDLE, ARMED, WRITE and DONE.
REQ-017 IDLE SHALL go to ARMED when start=1.
REQ-018 ARMED with sample=1 SHALL capture all ofm words into a holding register and go to WRITE.
REQ-019 WRITE SHALL emit BEATS=DSP_NO/LANES consecutive beats, ram_we=1 on each.
REQ-020 Beat b SHALL carry channels b*LANES .. b*LANES+LANES-1.
REQ-021 Beat b SHALL use ram_addr = pix*BEATS + b, where pix is the pixel counter (0 .. WOUT**2-1).
REQ-022 Latency: sample in cycle N SHALL give beat 0 in cycle N+1 and the last beat in cycle N+BEATS.
REQ-023 ram_feedback SHALL be 1 exactly in the cycles where ram_we=1.
REQ-024 A sample in the last-beat cycle SHALL be captured and start the next WRITE in the following cycle, with no gap.
REQ-025 A sample in any other WRITE cycle SHALL be dropped, and the holding register SHALL NOT change.
REQ-026 After the last beat, pix SHALL increment.
REQ-027 After the last beat, the FSM SHALL go to ARMED if pix < WOUT**2-1 before the increment.
REQ-028 After the last beat of pixel WOUT**2-1, the FSM SHALL go to DONE and pix SHALL wrap to 0.
REQ-029 DONE SHALL hold done=1 and ignore sample; start=0 SHALL return the FSM to IDLE next cycle.
REQ-030 start=0 in ARMED or WRITE SHALL abort to IDLE next cycle, with ram_we=0 from that cycle and pix cleared.
REQ-031 Samples in IDLE SHALL be ignored.
REQ-032 ram_we, ram_addr, ram_wdata, ram_feedback and done SHALL all be registered outputs.

Reset
REQ-033 rst=0 SHALL immediately force state IDLE, pix=0 and beat=0.
REQ-034 rst=0 SHALL immediately force ram_we=0, ram_addr=0, ram_wdata=0, ram_feedback=0, done=0 and overrun=0.
REQ-035 The holding register SHALL NOT be reset.
REQ-036 Reset mid-WRITE SHALL end the write burst in the same cycle, and no partial beat SHALL complete.

Configuration
REQ-037 With macro FIRE_OFM_WRITER_OVERRUN_DETECT_EN defined, any sample dropped under REQ-025 or seen in DONE SHALL set overrun=1.
REQ-038 With the macro defined, overrun SHALL clear only on reset or on the IDLE-to-ARMED transition.
REQ-039 Without the macro, overrun SHALL be tied to 0 and no detection logic SHALL be built.

Verification
REQ-040 Single pixel: start=1, one sample with ofm[k]=k -> cycles 1..16 have ram_we=1, ram_addr=0..15, and beat 0 ram_wdata = {16'd3,16'd2,16'd1,16'd0}.
REQ-041 Full layer: samples every 17 cycles, 4096 times -> 65536 writes with last ram_addr=65535, done=1 after the final beat, overrun=0.
REQ-042 Back-to-back: second sample on the last-beat cycle -> ram_we stays 1 for 32 consecutive cycles with ram_addr 0..31.
REQ-043 Collision: second sample at beat 5 -> dropped, exactly 16 writes, overrun=1 with the macro and overrun=0 without it.
REQ-044 Abort and reset: start=0 at beat 8 -> ram_we=0 next cycle and state IDLE; rst=0 mid-WRITE -> all outputs 0 immediately, and the next layer restarts at ram_addr=0.

Source files
------------

// File: rtl/fire_expand_ofm_writer_if.sv
// fire_expand_ofm_writer_if
//   Bundles the OFM writer handshake and RAM write bus.
//   master : producer side (drives start/sample/ofm, observes RAM bus + status)
//   slave  : the writer itself
//   Signals:
//     start        layer enable, high for the whole layer
//     sample       one-cycle pulse, ofm valid in that cycle
//     ofm          DSP_NO channel results of one pixel
//     ram_we       RAM write strobe
//     ram_addr     beat address (pix*BEATS + beat)
//     ram_wdata    LANES words, lane 0 in the LSBs
//     ram_feedback high while a beat is being written
//     done         all WOUT**2 pixels written
//     overrun      sticky dropped-sample flag (0 unless detection is built)
interface fire_expand_ofm_writer_if #(
    parameter int DSP_NO = 64,
    parameter int WIDTH  = 16,
    parameter int WOUT   = 64,
    parameter int LANES  = 4
);
    localparam int AW = $clog2(WOUT * WOUT * DSP_NO / LANES);

    logic                   start;
    logic                   sample;
    logic [WIDTH-1:0]       ofm [DSP_NO];
    logic                   ram_we;
    logic [AW-1:0]          ram_addr;
    logic [LANES*WIDTH-1:0] ram_wdata;
    logic                   ram_feedback;
    logic                   done;
    logic                   overrun;

    modport master (
        output start, sample, ofm,
        input  ram_we, ram_addr, ram_wdata, ram_feedback, done, overrun
    );

    modport slave (
        input  start, sample, ofm,
        output ram_we, ram_addr, ram_wdata, ram_feedback, done, overrun
    );
endinterface

// File: rtl/fire_expand_ofm_writer.sv
// fire_expand_ofm_writer
//   Captures one pixel's DSP_NO channel results on a sample pulse and writes
//   them to RAM as DSP_NO/LANES consecutive beats of LANES words each.
//   A whole layer is WOUT**2 pixels; done is raised after the last one.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-low reset
//     bus  fire_expand_ofm_writer_if.slave (start/sample/ofm in, RAM bus out)
//   Build option:
//     FIRE_OFM_WRITER_OVERRUN_DETECT_EN  builds the sticky overrun detector;
//     without it overrun is tied low.
module fire_expand_ofm_writer #(
    parameter int DSP_NO = 64,
    parameter int WIDTH  = 16,
    parameter int WOUT   = 64,
    parameter int LANES  = 4
) (
    input logic                   clk,
    input logic                   rst,
    fire_expand_ofm_writer_if.slave bus
);
    localparam int BEATS  = DSP_NO / LANES;
    localparam int PIXELS = WOUT * WOUT;
    localparam int AW     = $clog2(PIXELS * BEATS);
    localparam int PW     = (PIXELS > 1) ? $clog2(PIXELS) : 1;
    localparam int BW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DW     = LANES * WIDTH;

    typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE} state_t;

    state_t        state;
    logic [PW-1:0] pix;
    logic [BW-1:0] beat;      // index of the beat currently on the RAM bus
    logic          we_q;
    logic          fb_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          done_q;

    // Holding register, pre-sliced into beats; intentionally not reset.
    logic [DW-1:0] hold      [BEATS];
    logic [DW-1:0] cap_beats [BEATS];
    logic [DW-1:0] nxt_data;
    logic [BW-1:0] nxt_idx;

    logic last_beat;
    logic last_pix;
    logic cap;

    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            assign cap_beats[b][l*WIDTH +: WIDTH] = bus.ofm[b*LANES + l];
        end
    end

    assign last_beat = (beat == BW'(BEATS - 1));
    assign last_pix  = (pix == PW'(PIXELS - 1));
    assign nxt_idx   = beat + BW'(1);
    assign nxt_data  = hold[nxt_idx];

    // Capture in ARMED, or on the last beat of a non-final pixel so the next
    // burst follows without a gap. Any other WRITE cycle leaves hold alone.
    assign cap = bus.start && bus.sample &&
                 ((state == ARMED) ||
                  (state == WRITE && last_beat && !last_pix));

    always_ff @(posedge clk) begin
        if (cap) begin
            for (int b = 0; b < BEATS; b++) hold[b] <= cap_beats[b];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            pix     <= '0;
            beat    <= '0;
            we_q    <= 1'b0;
            fb_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    we_q <= 1'b0;
                    fb_q <= 1'b0;
                    pix  <= '0;
                    beat <= '0;
                    if (bus.start) state <= ARMED;
                end
                ARMED: begin
                    if (!bus.start) begin
                        state <= IDLE;
                        pix   <= '0;
                        beat  <= '0;
                    end else if (cap) begin
                        state   <= WRITE;
                        beat    <= '0;
                        we_q    <= 1'b1;
                        fb_q    <= 1'b1;
                        addr_q  <= AW'(pix) * AW'(BEATS);
                        wdata_q <= cap_beats[0];
                    end
                end
                WRITE: begin
                    if (!bus.start) begin
                        state <= IDLE;
                        we_q  <= 1'b0;
                        fb_q  <= 1'b0;
                        pix   <= '0;
                        beat  <= '0;
                    end else if (!last_beat) begin
                        beat    <= nxt_idx;
                        addr_q  <= addr_q + AW'(1);
                        wdata_q <= nxt_data;
                    end else if (last_pix) begin
                        state  <= DONE;
                        pix    <= '0;
                        beat   <= '0;
                        we_q   <= 1'b0;
                        fb_q   <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        pix  <= pix + PW'(1);
                        beat <= '0;
                        if (cap) begin
                            // next pixel's beat 0 directly follows: addr is contiguous
                            addr_q  <= addr_q + AW'(1);
                            wdata_q <= cap_beats[0];
                        end else begin
                            state <= ARMED;
                            we_q  <= 1'b0;
                            fb_q  <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        state  <= IDLE;
                        done_q <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIRE_OFM_WRITER_OVERRUN_DETECT_EN
    logic ovr_q;
    logic drop;

    // A sample is lost when it lands mid-burst or after the layer finished.
    assign drop = bus.sample &&
                  ((state == WRITE && bus.start && !last_beat) ||
                   (state == DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          ovr_q <= 1'b0;
        else if (state == IDLE && bus.start) ovr_q <= 1'b0;
        else if (drop)                     ovr_q <= 1'b1;
    end

    assign bus.overrun = ovr_q;
`else
    assign bus.overrun = 1'b0;
`endif

    assign bus.ram_we       = we_q;
    assign bus.ram_feedback = fb_q;
    assign bus.ram_addr     = addr_q;
    assign bus.ram_wdata    = wdata_q;
    assign bus.done         = done_q;
endmodule

// File: tb/tb_fire_expand_ofm_writer.sv
module tb_fire_expand_ofm_writer;
    localparam int DSP_NO = 64;
    localparam int WIDTH  = 16;
    localparam int WOUT   = 64;
    localparam int LANES  = 4;
    localparam int BEATS  = DSP_NO / LANES;
    localparam int PIXELS = WOUT * WOUT;

`ifdef FIRE_OFM_WRITER_OVERRUN_DETECT_EN
    localparam logic OVR_EXP = 1'b1;
`else
    localparam logic OVR_EXP = 1'b0;
`endif

    typedef struct {
        int          cyc;
        int          addr;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        int          beat;
        logic [63:0] exp_data;
        int          exp_addr;
    } vec_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    int   fb_bad;
    wr_t  wq[$];
    wr_t  exq[$];

    fire_expand_ofm_writer_if #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .WOUT(WOUT), .LANES(LANES)) bus ();

    fire_expand_ofm_writer #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .WOUT(WOUT), .LANES(LANES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (bus.ram_we) wq.push_back('{cyc, int'(bus.ram_addr), bus.ram_wdata});
            if (bus.ram_feedback !== bus.ram_we) fb_bad++;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_lin(input logic [15:0] base, input logic [15:0] stp);
        for (int k = 0; k < DSP_NO; k++) bus.ofm[k] = base + 16'(k) * stp;
    endtask

    task automatic set_rand();
        for (int k = 0; k < DSP_NO; k++) bus.ofm[k] = 16'($urandom);
    endtask

    function automatic logic [63:0] beat_of(input int b);
        logic [63:0] r;
        for (int l = 0; l < LANES; l++) r[l*WIDTH +: WIDTH] = bus.ofm[b*LANES + l];
        return r;
    endfunction

    // sample pulse in the current cycle; returns that cycle number
    task automatic pulse(output int c);
        c = cyc;
        bus.sample = 1'b1;
        step(1);
        bus.sample = 1'b0;
    endtask

    // leave any previous layer and arm a fresh one
    task automatic new_layer();
        bus.start  = 1'b0;
        bus.sample = 1'b0;
        step(2);
        wq.delete();
        bus.start = 1'b1;
        step(1);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_we"},    64'(bus.ram_we),       64'd0);
        chk({tag, "_addr"},  64'(bus.ram_addr),     64'd0);
        chk({tag, "_wdata"}, bus.ram_wdata,         64'd0);
        chk({tag, "_fb"},    64'(bus.ram_feedback), 64'd0);
        chk({tag, "_done"},  64'(bus.done),         64'd0);
        chk({tag, "_ovr"},   64'(bus.overrun),      64'd0);
    endtask

    vec_t vecs[4];

    initial begin
        int c, c2, bad;
        logic [63:0] d;
        cyc = 0; tests = 0; fails = 0; fb_bad = 0;
        rst = 1'b0;
        bus.start = 1'b0;
        bus.sample = 1'b0;
        set_lin(16'd0, 16'd0);

        vecs[0] = '{16'h0000, 16'h0001, 0,  64'h0003_0002_0001_0000, 0};
        vecs[1] = '{16'h0000, 16'h0001, 15, 64'h003F_003E_003D_003C, 15};
        vecs[2] = '{16'h1000, 16'h0100, 1,  64'h1700_1600_1500_1400, 1};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 2,  64'hFFF4_FFF5_FFF6_FFF7, 2};

        // reset state
        step(3);
        check_outputs_zero("reset");
        rst = 1'b1;
        step(2);
        check_outputs_zero("idle");

        // single-pixel table; ofm is scrambled after the sample so only the
        // captured copy can produce the expected data
        foreach (vecs[i]) begin
            new_layer();
            set_lin(vecs[i].base, vecs[i].step);
            pulse(c);
            set_rand();
            step(20);
            chk($sformatf("tbl%0d_count", i), 64'(wq.size()), 64'd16);
            if (wq.size() == 16) begin
                chk($sformatf("tbl%0d_data", i), wq[vecs[i].beat].data, vecs[i].exp_data);
                chk($sformatf("tbl%0d_addr", i), 64'(wq[vecs[i].beat].addr), 64'(vecs[i].exp_addr));
                chk($sformatf("tbl%0d_first_cyc", i), 64'(wq[0].cyc), 64'(c + 1));
                chk($sformatf("tbl%0d_last_cyc", i), 64'(wq[15].cyc), 64'(c + BEATS));
            end
        end

        // back-to-back: second sample on the last-beat cycle
        new_layer();
        set_lin(16'd0, 16'd1);
        pulse(c);
        set_rand();
        step(BEATS - 1);
        set_lin(16'h8000, 16'd3);
        pulse(c2);
        set_rand();
        step(20);
        chk("b2b_second_cyc", 64'(c2), 64'(c + BEATS));
        chk("b2b_count", 64'(wq.size()), 64'd32);
        bad = 0;
        foreach (wq[i]) if (wq[i].addr != i || wq[i].cyc != c + 1 + i) bad++;
        chk("b2b_contig", 64'(bad), 64'd0);
        if (wq.size() == 32) begin
            chk("b2b_p0_last", wq[15].data, 64'h003F_003E_003D_003C);
            chk("b2b_p1_first", wq[16].data, 64'h8009_8006_8003_8000);
        end
        chk("b2b_ovr", 64'(bus.overrun), 64'd0);

        // collision: second sample while beat 5 is on the bus
        new_layer();
        set_lin(16'd0, 16'd1);
        pulse(c);
        step(5);
        set_lin(16'h5555, 16'd1);
        pulse(c2);
        step(20);
        chk("col_count", 64'(wq.size()), 64'd16);
        if (wq.size() == 16) chk("col_hold", wq[15].data, 64'h003F_003E_003D_003C);
        chk("col_ovr", 64'(bus.overrun), 64'(OVR_EXP));

        // abort at beat 8, then ignored samples in IDLE, then restart
        new_layer();
        chk("ovr_cleared", 64'(bus.overrun), 64'd0);
        set_lin(16'd0, 16'd1);
        pulse(c);
        step(8);
        bus.start = 1'b0;
        step(1);
        chk("abort_we", 64'(bus.ram_we), 64'd0);
        step(3);
        chk("abort_count", 64'(wq.size()), 64'd9);
        pulse(c);
        step(BEATS + 2);
        chk("idle_ignore", 64'(wq.size()), 64'd9);
        bus.start = 1'b1;
        step(1);
        pulse(c);
        step(20);
        chk("restart_count", 64'(wq.size()), 64'd25);
        if (wq.size() == 25) begin
            chk("restart_addr", 64'(wq[9].addr), 64'd0);
            chk("restart_cyc", 64'(wq[9].cyc), 64'(c + 1));
        end

        // asynchronous reset mid-burst
        new_layer();
        set_lin(16'd0, 16'd1);
        pulse(c);
        step(4);
        #1 rst = 1'b0;
        #1;
        check_outputs_zero("rstmid");
        chk("rstmid_partial", 64'(wq.size()), 64'd4);
        step(2);
        rst = 1'b1;
        wq.delete();
        step(1);
        pulse(c);
        step(20);
        chk("rst_restart_count", 64'(wq.size()), 64'd16);
        if (wq.size() == 16) chk("rst_restart_addr", 64'(wq[0].addr), 64'd0);

        // randomized run against a timeline model: an accepted sample owns
        // the following BEATS cycles; a new one is taken from its last beat on
        begin
            int last_end, pix, gap;
            bit dropped;
            new_layer();
            exq.delete();
            last_end = -1; pix = 0; dropped = 0;
            for (int n = 0; n < 60; n++) begin
                gap = $urandom_range(0, 20);
                step(gap);
                set_rand();
                if (cyc >= last_end) begin
                    for (int b = 0; b < BEATS; b++)
                        exq.push_back('{cyc + 1 + b, pix * BEATS + b, beat_of(b)});
                    last_end = cyc + BEATS;
                    pix++;
                end else begin
                    dropped = 1'b1;
                end
                pulse(c);
            end
            step(BEATS + 4);
            chk("rnd_count", 64'(wq.size()), 64'(exq.size()));
            bad = 0;
            for (int i = 0; i < exq.size() && i < wq.size(); i++)
                if (wq[i].cyc != exq[i].cyc || wq[i].addr != exq[i].addr || wq[i].data !== exq[i].data) begin
                    if (bad < 4) $display("FAIL rnd_write[%0d]: got cyc %0d addr %0d data %0h expected cyc %0d addr %0d data %0h",
                        i, wq[i].cyc, wq[i].addr, wq[i].data, exq[i].cyc, exq[i].addr, exq[i].data);
                    bad++;
                end
            chk("rnd_writes", 64'(bad), 64'd0);
            chk("rnd_ovr", 64'(bus.overrun), 64'(OVR_EXP & dropped));
        end

        // full layer, one sample every BEATS+1 cycles
        new_layer();
        for (int p = 0; p < PIXELS; p++) begin
            bus.ofm[0] = 16'(p);
            pulse(c);
            step(BEATS);
        end
        chk("full_done", 64'(bus.done), 64'd1);
        chk("full_count", 64'(wq.size()), 64'(PIXELS * BEATS));
        if (wq.size() > 0) chk("full_last_addr", 64'(wq[wq.size()-1].addr), 64'(PIXELS * BEATS - 1));
        bad = 0;
        foreach (wq[i]) if (wq[i].addr != i) bad++;
        chk("full_seq", 64'(bad), 64'd0);
        chk("full_ovr", 64'(bus.overrun), 64'd0);
        pulse(c);
        step(3);
        chk("done_ignore", 64'(wq.size()), 64'(PIXELS * BEATS));
        chk("done_hold", 64'(bus.done), 64'd1);
        chk("done_ovr", 64'(bus.overrun), 64'(OVR_EXP));
        bus.start = 1'b0;
        step(1);
        chk("done_clear", 64'(bus.done), 64'd0);

        chk("feedback_eq_we", 64'(fb_bad), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
